axi3_mem_responder: RTL and testbench
=====================================

AXI3_MEM_RESPONDER -- requirements
Module: axi3_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of AW/AR.
REQ-002 Parameter ID_WIDTH, default 6, transaction ID width.
REQ-003 Parameter MEM_WORDS_LOG2, default 10, log2 of the number of 64-bit memory words.
REQ-004 CLK  in  1  single clock for all logic.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-007 s_axi_awlen  in  4  write beats minus one.
REQ-008 s_axi_awid  in  ID_WIDTH  write transaction ID.
REQ-009 s_axi_awvalid  in  1  write address valid.
REQ-010 s_axi_awready  out  1  write address accepted.
REQ-011 s_axi_wdata  in  64  write beat data.
REQ-012 s_axi_wstrb  in  8  per-byte write enables.
REQ-013 s_axi_wlast  in  1  initiator's final-beat marker.
REQ-014 s_axi_wvalid  in  1  write data valid.
REQ-015 s_axi_wready  out  1  write data accepted.
REQ-016 s_axi_bid  out  ID_WIDTH  echoed awid.
REQ-017 s_axi_bresp  out  2  write response code.
REQ-018 s_axi_bvalid  out  1  write response valid.
REQ-019 s_axi_bready  in  1  write response accepted.
REQ-020 s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-021 s_axi_arlen  in  4  read beats minus one.
REQ-022 s_axi_arid  in  ID_WIDTH  read transaction ID.
REQ-023 s_axi_arvalid  in  1  read address valid.
REQ-024 s_axi_arready  out  1  read address accepted.
REQ-025 s_axi_rdata  out  64  read beat data.
REQ-026 s_axi_rid  out  ID_WIDTH  echoed arid.
REQ-027 s_axi_rresp  out  2  read response, always OKAY (2'b00).
REQ-028 s_axi_rlast  out  1  final read beat.
REQ-029 s_axi_rvalid  out  1  read data valid.
REQ-030 s_axi_rready  in  1  read data accepted.

Function
REQ-031 Bursts SHALL be INCR with 8-byte beats; word index = addr[MEM_WORDS_LOG2+2:3]; upper bits and addr[2:0] are ignored (aliasing); index wraps modulo 2^MEM_WORDS_LOG2.
REQ-032 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE; AW handshake latches index, len, id.
REQ-033 In W_DATA, wready=1; each W handshake writes bytes selected by wstrb, increments index and beat count; handshake at beat==len moves to W_RESP.
REQ-034 Beat count, not wlast, ends the burst; bresp SHALL be SLVERR (2'b10) if wlast differed from (beat==len) on any beat, else OKAY.
REQ-035 In W_RESP, bvalid=1 with bid/bresp held stable until bready; the handshake returns to W_IDLE, awready=1 the following cycle.
REQ-036 Read FSM SHALL be R_IDLE -> R_DATA -> R_IDLE; arready=1 only in R_IDLE; first rvalid exactly one cycle after the AR handshake.
REQ-037 rdata/rid/rlast SHALL stay stable while rvalid & !rready; next word is fetched only on an R handshake; rlast=1 only on beat==len; last handshake returns to R_IDLE.
REQ-038 Read and write channels SHALL run concurrently; same-word same-cycle read/write returns the old data (read-first).

Reset
REQ-039 RST_N low SHALL immediately force both FSMs to IDLE, bvalid/rvalid/rlast/wready=0, awready/arready=0 during reset and 1 the first cycle after release, bid/rid/bresp/rdata=0; memory contents are not reset.

Structure
REQ-040 Package axi3_mem_pkg SHALL hold the W/R state enums and resp constants OKAY=2'b00, SLVERR=2'b10.
REQ-041 Memory SHALL be a sub-module bram_be_sdp: simple dual-port, 64-bit, byte-enable write, synchronous read-first read with read enable.

Verification
REQ-042 Write 0x10, len 0, id 5, data 0x1122334455667788, strb 0xFF -> bvalid one cycle after W beat, bid 5, bresp 00; read 0x10 id 5 -> same data, rlast 1, rid 5.
REQ-043 Write len 3 at 0x100, beat 2 strb 0x0F over prior 0xFFFF...FF -> read len 3 gives 4 beats, beat 2 = 0xFFFFFFFF_<new low>, rlast only on beat 3.
REQ-044 rready low 5 cycles mid read burst -> rdata/rid/rlast constant, no beat lost or repeated.
REQ-045 len 3 write with wlast on beat 1 -> all 4 beats accepted, bresp 2'b10.
REQ-046 Write/read len 3 at word 1022 (MEM_WORDS_LOG2=10) -> words 1022,1023,0,1 touched.
REQ-047 RST_N low mid read burst -> rvalid 0 same cycle; after release arready=1, earlier written data still readable.

Source files
------------

// File: rtl/axi3_mem_pkg.sv
// Shared types and response codes for the AXI3 memory responder.
package axi3_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/bram_be_sdp.sv
// Simple dual-port 64-bit RAM: byte-enable write port, registered read-first read port.
module bram_be_sdp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wstrb_i,
  input  logic [63:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [63:0]       rdata_o
);

  logic [63:0] mem_q [2**ADDR_W];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi3_mem_responder.sv
// AXI3 INCR-burst slave backed by a 64-bit byte-enable RAM; independent read and write FSMs.
module axi3_mem_responder
  import axi3_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 6,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [3:0]            s_axi_awlen,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [3:0]            s_axi_arlen,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [63:0]           s_axi_rdata,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int MW = MEM_WORDS_LOG2;

  w_state_e            w_state_q, w_state_d;
  logic [MW-1:0]       widx_q, widx_d;
  logic [3:0]          wlen_q, wlen_d;
  logic [3:0]          wbeat_q, wbeat_d;
  logic                werr_q, werr_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;

  r_state_e            r_state_q, r_state_d;
  logic [MW-1:0]       ridx_q, ridx_d;
  logic [3:0]          rlen_q, rlen_d;
  logic [3:0]          rbeat_q, rbeat_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;

  logic                mem_we;
  logic                mem_re;
  logic [MW-1:0]       mem_raddr;
  logic                w_last_beat;
  logic                r_last_beat;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:MW+3], s_axi_awaddr[2:0],
                              s_axi_araddr[ADDR_WIDTH-1:MW+3], s_axi_araddr[2:0]};

  assign w_last_beat = (wbeat_q == wlen_q);
  assign r_last_beat = (rbeat_q == rlen_q);

  // Write channel
  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          widx_d    = s_axi_awaddr[MW+2:3];
          wlen_d    = s_axi_awlen;
          bid_d     = s_axi_awid;
          wbeat_d   = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we  = 1'b1;
          widx_d  = widx_q + 1'b1;
          wbeat_d = wbeat_q + 4'd1;
          // A misplaced wlast only taints the response; the beat count still ends the burst.
          werr_d  = werr_q | (s_axi_wlast != w_last_beat);
          if (w_last_beat) begin
            bresp_d   = werr_d ? SLVERR : OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w_state_q <= W_IDLE;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read channel: ridx_q always points at the word to fetch for the next beat.
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rid_d     = rid_q;
    mem_re    = 1'b0;
    mem_raddr = ridx_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          mem_re    = 1'b1;
          mem_raddr = s_axi_araddr[MW+2:3];
          ridx_d    = s_axi_araddr[MW+2:3] + 1'b1;
          rlen_d    = s_axi_arlen;
          rid_d     = s_axi_arid;
          rbeat_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            mem_re  = 1'b1;
            ridx_d  = ridx_q + 1'b1;
            rbeat_d = rbeat_q + 4'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state_q <= R_IDLE;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rid_q     <= rid_d;
    end
  end

  bram_be_sdp #(
    .ADDR_W (MW)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .we_i    (mem_we),
    .waddr_i (widx_q),
    .wstrb_i (s_axi_wstrb),
    .wdata_i (s_axi_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (s_axi_rdata)
  );

  // Address readies are gated by reset so they read 0 while RST_N is held low.
  assign s_axi_awready = RST_N && (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  assign s_axi_arready = RST_N && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rlast   = (r_state_q == R_DATA) && r_last_beat;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = OKAY;

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Directed plus randomized bench for axi3_mem_responder against a word-array memory model.
module tb_axi3_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [5:0]  awid;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [5:0]  arid;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [5:0]  rid;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [1024];
  logic [63:0] wbeats [16];
  logic [7:0]  wstrbs [16];

  axi3_mem_responder #(
    .ADDR_WIDTH     (32),
    .ID_WIDTH       (6),
    .MEM_WORDS_LOG2 (10)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awid    (awid),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arid    (arid),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rid     (rid),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat);
    return ((int'(addr >> 3)) + beat) % 1024;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [5:0] id,
                          input logic [15:0] wl_mask, input bit gaps);
    int n;
    int stall;
    bit err;
    int ix;
    err = 1'b0;
    awaddr = addr; awlen = len[3:0]; awid = id; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin step(); n++; end
    chk("aw_wait", awready, 1);
    step();
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        step();
      end
      wdata = wbeats[b]; wstrb = wstrbs[b]; wlast = wl_mask[b]; wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin step(); n++; end
      chk("w_wait", wready, 1);
      step();
      ix = widx(addr, b);
      for (int k = 0; k < 8; k++)
        if (wstrbs[b][k]) model[ix][8*k +: 8] = wbeats[b][8*k +: 8];
      if (wl_mask[b] != (b == len)) err = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    stall = gaps ? int'($urandom_range(0, 3)) : 0;
    for (int s = 0; s <= stall; s++) begin
      chk("bvalid", bvalid, 1);
      chk("bid", bid, id);
      chk("bresp", bresp, err ? 2'b10 : 2'b00);
      if (s < stall) step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [5:0] id,
                         input int stall_beat, input int stall_n, input bit rnd);
    int n;
    int k;
    logic [63:0] exp;
    araddr = addr; arlen = len[3:0]; arid = id; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin step(); n++; end
    chk("ar_wait", arready, 1);
    step();
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1);
    for (int b = 0; b <= len; b++) begin
      exp = model[widx(addr, b)];
      k = (b == stall_beat) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < k; s++) begin
        step();
        chk("stall_rvalid", rvalid, 1);
        chk("stall_rdata", rdata, exp);
        chk("stall_rlast", rlast, (b == len));
        chk("stall_rid", rid, id);
      end
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, exp);
      chk("rid", rid, id);
      chk("rlast", rlast, (b == len));
      chk("rresp", rresp, 2'b00);
      rready = 1'b1;
      step();
      rready = 1'b0;
    end
    chk("rvalid_end", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  task automatic fill_beats(input int len, input bit rnd_strb);
    for (int b = 0; b <= len; b++) begin
      wbeats[b] = {$urandom(), $urandom()};
      wstrbs[b] = rnd_strb ? 8'($urandom_range(0, 255)) : 8'hFF;
    end
  endtask

  function automatic logic [15:0] good_last(input int len);
    logic [15:0] m;
    m = '0;
    m[len] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [31:0] a;
    logic [63:0] old_w, new_w;
    int len;
    logic [15:0] m;

    rst_n = 1'b0;
    awaddr = '0; awlen = '0; awid = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arid = '0; arvalid = 1'b0; rready = 1'b0;
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);
    step();

    // Single-beat write and read-back
    wbeats[0] = 64'h1122334455667788; wstrbs[0] = 8'hFF;
    do_write(32'h10, 0, 6'd5, 16'h0001, 1'b0);
    chk("single_model", model[2], 64'h1122334455667788);
    do_read(32'h10, 0, 6'd5, -1, 0, 1'b0);

    // Partial strobe over an all-ones burst
    for (int b = 0; b < 4; b++) begin wbeats[b] = '1; wstrbs[b] = 8'hFF; end
    do_write(32'h100, 3, 6'd1, good_last(3), 1'b0);
    fill_beats(3, 1'b0);
    wstrbs[2] = 8'h0F;
    new_w = wbeats[2];
    do_write(32'h100, 3, 6'd2, good_last(3), 1'b0);
    chk("partial_model", model[34], {32'hFFFF_FFFF, new_w[31:0]});
    do_read(32'h100, 3, 6'd7, -1, 0, 1'b0);

    // Read backpressure mid-burst
    do_read(32'h100, 3, 6'd9, 1, 5, 1'b0);

    // Early wlast still takes all beats and flags SLVERR
    fill_beats(3, 1'b0);
    do_write(32'h300, 3, 6'd11, 16'h0002, 1'b0);
    do_read(32'h300, 3, 6'd11, -1, 0, 1'b0);

    // Warm words 0..63 with max-length bursts
    for (int g = 0; g < 4; g++) begin
      fill_beats(15, 1'b0);
      do_write(32'(g * 128), 15, 6'(g), good_last(15), 1'b1);
    end

    // Wrap at the top of memory, with ignored upper and low address bits
    fill_beats(3, 1'b0);
    a = 32'h5A5A_0000 | (32'd1022 << 3) | 32'd5;
    do_write(a, 3, 6'd33, good_last(3), 1'b0);
    do_read(32'h0000_1FF0, 3, 6'd34, -1, 0, 1'b0);
    do_read(32'h0000_0000, 1, 6'd35, -1, 0, 1'b0);

    // Randomized mix
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 15);
      a = ($urandom() & 32'hFFFF_E000) | (32'($urandom_range(0, 48)) << 3) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        fill_beats(len, 1'b1);
        m = good_last(len);
        if ($urandom_range(0, 3) == 0) m[$urandom_range(0, len)] ^= 1'b1;
        do_write(a, len, 6'($urandom_range(0, 63)), m, 1'b1);
      end else begin
        do_read(a, len, 6'($urandom_range(0, 63)), -1, 0, 1'b1);
      end
    end

    // Same-word same-cycle write and read: read sees the old data
    wbeats[0] = 64'hA5A5_0000_1234_5678; wstrbs[0] = 8'hFF;
    do_write(32'h640, 0, 6'd1, 16'h0001, 1'b0);
    old_w = model[200];
    new_w = 64'h0BAD_F00D_CAFE_BEEF;
    awaddr = 32'h640; awlen = 4'd0; awid = 6'd3; awvalid = 1'b1;
    chk("coll_awready", awready, 1);
    step();
    awvalid = 1'b0;
    wdata = new_w; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h640; arlen = 4'd0; arid = 6'd9; arvalid = 1'b1;
    chk("coll_wready", wready, 1);
    chk("coll_arready", arready, 1);
    step();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata_old", rdata, old_w);
    chk("coll_rid", rid, 9);
    chk("coll_rlast", rlast, 1);
    chk("coll_bvalid", bvalid, 1);
    chk("coll_bid", bid, 3);
    chk("coll_bresp", bresp, 0);
    model[200] = new_w;
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    chk("coll_rvalid_end", rvalid, 0);
    chk("coll_bvalid_end", bvalid, 0);
    do_read(32'h640, 0, 6'd4, -1, 0, 1'b0);

    // Reset in the middle of a read burst
    araddr = 32'h100; arlen = 4'd3; arid = 6'd12; arvalid = 1'b1;
    chk("mid_arready", arready, 1);
    step();
    arvalid = 1'b0;
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("mid_rvalid", rvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_arready", arready, 0);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rid", rid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("mid_post_arready", arready, 1);
    chk("mid_post_awready", awready, 1);
    chk("mid_post_rvalid", rvalid, 0);
    step();
    do_read(32'h100, 3, 6'd13, -1, 0, 1'b0);
    do_read(32'h10, 0, 6'd14, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
